cpu_result_probe: RTL
=====================

# cpu_result_probe

Parametrised result-register probe for the CDEC CPU shell. It generalises the fixed 2-bit select / two-byte result readout to NREG registers of DATA_W bits. It adds snapshot capture on end-of-sequence or on demand, a hold/live state machine, a capture counter and optional auto-scan. It sits between the CPU core's register file outputs and the board display/debug logic.

## Interface
- DATA_W, 16: register width; even, ≥ 4; resdt_h/resdt_l are DATA_W/2 each.
- NREG, 4: number of probed registers, 2..16.
- SEL_W, $clog2(NREG): select width (derived).
- SCAN_DIV, 50_000_000: clock cycles per auto-scan step, ≥ 2.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- reg_flat  in  NREG*DATA_W  live register values; register i at bits [i*DATA_W +: DATA_W].
- endseq  in  1  CPU end-of-sequence level; its rising edge triggers capture.
- cap_req  in  1  one-cycle manual capture request.
- release  in  1  one-cycle request to return from HOLD to LIVE.
- ressel  in  SEL_W  manual register select.
- scan_en  in  1  auto-scan enable; present only with CPU_PROBE_SCAN_EN.
- resdt_h  out  DATA_W/2  upper half of displayed value.
- resdt_l  out  DATA_W/2  lower half of displayed value.
- cur_sel  out  SEL_W  index currently displayed.
- snap_valid  out  1  snapshot bank holds a capture.
- hold  out  1  state is HOLD.
- cap_count  out  8  number of captures since reset; saturates at 255.

## Operation
- States: LIVE (reset), HOLD.
- Capture event = (endseq & ~endseq_d) | cap_req. endseq_d is endseq registered, reset 0.
- On a capture event, in either state: all NREG registers copy into the snapshot bank. snap_valid←1, state←HOLD, cap_count←min(cap_count+1, 255).
- release in HOLD with no capture event in the same cycle: state←LIVE. The snapshot bank and snap_valid are kept.
- release in LIVE: ignored.
- Capture and release in the same cycle: capture wins; state stays or becomes HOLD.
- Select source: ressel normally; the scan index when scan is active.
- Displayed value: in LIVE, the live reg_flat word at the selected index; in HOLD, the snapshot word.
- The value is split: resdt_h = value[DATA_W-1:DATA_W/2], resdt_l = value[DATA_W/2-1:0].
- Select index ≥ NREG (NREG not a power of two): the displayed value is 0 and cur_sel still shows the index.
- reset, including mid-HOLD or mid-scan: state LIVE, snapshot bank 0, snap_valid 0, cap_count 0, scan index 0, scan divider 0.
- reset also forces all outputs to 0.

## Timing
- All outputs are registered.
- Select or live data change at edge k: resdt_h/resdt_l/cur_sel reflect it at edge k+1, i.e. 1-cycle latency.
- endseq first sampled high at edge k: the bank captures reg_flat as sampled at edge k. hold, snap_valid and cap_count update at edge k. resdt shows the snapshot from edge k+1.
- cap_req sampled high at edge k: same timing as endseq.
- endseq held high creates exactly one capture. A new capture needs endseq low for ≥ 1 cycle.
- release at edge k: hold=0 at edge k; live data shown from edge k+1.

## Configuration
- CPU_PROBE_SCAN_EN defined:
  - scan_en port exists.
  - When scan_en=1, the divider counts 0..SCAN_DIV-1. On wrap, the scan index advances by 1, wrapping NREG-1→0, and ressel is ignored.
  - When scan_en=0, the divider and index are held at 0 and ressel is used.
  - Raising scan_en starts from index 0.
- CPU_PROBE_SCAN_EN undefined:
  - No scan_en port and no divider logic.
  - The select is always ressel.

## Structure
- Package cpu_probe_pkg: state enum (LIVE, HOLD), CAP_COUNT_W=8, default DATA_W/NREG constants.
- Sub-module probe_scan_timer, instantiated only under CPU_PROBE_SCAN_EN:
  - Inputs: clock, reset, scan_en.
  - Output: scan index.
  - Parameters: SCAN_DIV, NREG.
- Snapshot bank, edge detect, FSM and output mux live in the top module.

## Test plan
- Reset: after reset held 2 cycles, NREG=4, DATA_W=16 → all outputs 0, hold=0.
- Live select: reg1=0xA55A, ressel=1 → next cycle resdt_h=0xA5, resdt_l=0x5A, cur_sel=1.
- endseq capture:
  - Stimulus: reg2=0x1234, endseq rises and is held 5 cycles; reg2 then changes to 0xFFFF; ressel=2.
  - Response: resdt stays 0x12/0x34, cap_count=1, hold=1.
  - Then release → 0xFF/0xFF next cycle.
- Simultaneous events: cap_req and release in the same cycle while in HOLD → hold stays 1, cap_count+1, bank refreshed.
- Saturation and reset: 300 cap_req pulses → cap_count=255. A reset mid-HOLD → hold=0, snap_valid=0, cap_count=0.
- Scan (macro on, SCAN_DIV=4, NREG=3): scan_en=1 → cur_sel sequence 0,1,2,0 with each value held 4 cycles; ressel changes are ignored.

Source files
------------

// File: rtl/cpu_probe_pkg.sv
// Shared types and constants for the CDEC CPU result-register probe.
// Holds the LIVE/HOLD state type, the capture counter width and defaults.
package cpu_probe_pkg;

   typedef enum logic {
      LIVE = 1'b0,
      HOLD = 1'b1
   } probe_state_e;

   localparam int CAP_COUNT_W  = 8;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_NREG     = 4;
   localparam int DEF_SCAN_DIV = 50_000_000;

   // Saturating increment: sticks at all-ones.
   function automatic logic [CAP_COUNT_W-1:0] sat_inc(
      input logic [CAP_COUNT_W-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/probe_scan_timer.sv
// Auto-scan index generator: steps through 0..NREG-1 every SCAN_DIV cycles.
// Ports: clock, reset (sync, high), scan_en in; scan_idx out (SEL_W bits).
module probe_scan_timer
   import cpu_probe_pkg::*;
#(
   parameter int SCAN_DIV = DEF_SCAN_DIV,
   parameter int NREG     = DEF_NREG,
   parameter int SEL_W    = $clog2(NREG)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             scan_en,
   output logic [SEL_W-1:0] scan_idx
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NREG - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [SEL_W-1:0] idx_q, idx_d;

   // Disabled scan parks both counters at zero, so raising scan_en
   // always restarts the sweep from register 0.
   always_comb begin
      div_d = div_q;
      idx_d = idx_q;
      if (!scan_en) begin
         div_d = '0;
         idx_d = '0;
      end else if (div_q == DIV_LAST) begin
         div_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         div_q <= '0;
         idx_q <= '0;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
      end
   end

   assign scan_idx = idx_q;

endmodule

// File: rtl/cpu_result_probe.sv
// Result-register probe: live/snapshot readout of NREG registers, split in halves.
// In: clock, reset, reg_flat, endseq, cap_req, release_req, ressel
//     (+ scan_en when CPU_PROBE_SCAN_EN is defined).
// Out: resdt_h, resdt_l, cur_sel, snap_valid, hold, cap_count (all registered).
module cpu_result_probe
   import cpu_probe_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NREG     = DEF_NREG,
   parameter int SEL_W    = $clog2(NREG),
   parameter int SCAN_DIV = DEF_SCAN_DIV
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NREG*DATA_W-1:0] reg_flat,
   input  logic                   endseq,
   input  logic                   cap_req,
   input  logic                   release_req,
   input  logic [SEL_W-1:0]       ressel,
`ifdef CPU_PROBE_SCAN_EN
   input  logic                   scan_en,
`endif
   output logic [DATA_W/2-1:0]    resdt_h,
   output logic [DATA_W/2-1:0]    resdt_l,
   output logic [SEL_W-1:0]       cur_sel,
   output logic                   snap_valid,
   output logic                   hold,
   output logic [CAP_COUNT_W-1:0] cap_count
);

   localparam int HALF = DATA_W / 2;

   if (DATA_W < 4 || (DATA_W % 2) != 0) begin : g_bad_data_w
      $error("cpu_result_probe: DATA_W must be even and >= 4");
   end
   if (NREG < 2 || NREG > 16) begin : g_bad_nreg
      $error("cpu_result_probe: NREG must be 2..16");
   end
   if (SCAN_DIV < 2) begin : g_bad_scan_div
      $error("cpu_result_probe: SCAN_DIV must be >= 2");
   end

   probe_state_e state_q, state_d;

   logic                   endseq_q, endseq_d;
   logic [NREG*DATA_W-1:0] bank_q, bank_d;
   logic                   snap_valid_q, snap_valid_d;
   logic [CAP_COUNT_W-1:0] cap_count_q, cap_count_d;
   logic [DATA_W-1:0]      disp_q, disp_d;
   logic [SEL_W-1:0]       cur_sel_q, cur_sel_d;

   logic                   cap_evt;
   logic                   hold_s;
   logic                   show_snap;
   logic [SEL_W-1:0]       sel;
   logic [NREG*DATA_W-1:0] src;

   // ---- select source
`ifdef CPU_PROBE_SCAN_EN
   logic [SEL_W-1:0] scan_idx;

   probe_scan_timer #(
      .SCAN_DIV (SCAN_DIV),
      .NREG     (NREG),
      .SEL_W    (SEL_W)
   ) u_scan (
      .clock    (clock),
      .reset    (reset),
      .scan_en  (scan_en),
      .scan_idx (scan_idx)
   );

   assign sel = scan_en ? scan_idx : ressel;
`else
   assign sel = ressel;
`endif

   // A held-high endseq yields one capture; only its rising edge counts.
   assign cap_evt = (endseq & ~endseq_q) | cap_req;

   // ---- FSM: state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= LIVE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- FSM: next state (capture beats release)
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LIVE: begin
            if (cap_evt) state_d = HOLD;
         end
         HOLD: begin
            if (!cap_evt && release_req) state_d = LIVE;
         end
      endcase
   end

   // ---- FSM: outputs
   always_comb begin
      hold_s    = 1'b0;
      show_snap = 1'b0;
      unique case (state_q)
         LIVE: begin
            hold_s    = 1'b0;
            show_snap = 1'b0;
         end
         HOLD: begin
            hold_s    = 1'b1;
            show_snap = 1'b1;
         end
      endcase
   end

   // ---- snapshot bank, edge detect, counter
   always_comb begin
      endseq_d     = endseq;
      bank_d       = bank_q;
      snap_valid_d = snap_valid_q;
      cap_count_d  = cap_count_q;
      if (cap_evt) begin
         bank_d       = reg_flat;
         snap_valid_d = 1'b1;
         cap_count_d  = sat_inc(cap_count_q);
      end
   end

   // ---- display mux; indices at or above NREG read as zero
   always_comb begin
      src       = show_snap ? bank_q : reg_flat;
      disp_d    = '0;
      cur_sel_d = sel;
      for (int i = 0; i < NREG; i++) begin
         if (sel == SEL_W'(i)) begin
            disp_d = src[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         endseq_q     <= 1'b0;
         bank_q       <= '0;
         snap_valid_q <= 1'b0;
         cap_count_q  <= '0;
         disp_q       <= '0;
         cur_sel_q    <= '0;
      end else begin
         endseq_q     <= endseq_d;
         bank_q       <= bank_d;
         snap_valid_q <= snap_valid_d;
         cap_count_q  <= cap_count_d;
         disp_q       <= disp_d;
         cur_sel_q    <= cur_sel_d;
      end
   end

   assign resdt_h    = disp_q[DATA_W-1 -: HALF];
   assign resdt_l    = disp_q[HALF-1:0];
   assign cur_sel    = cur_sel_q;
   assign snap_valid = snap_valid_q;
   assign hold       = hold_s;
   assign cap_count  = cap_count_q;

endmodule
